fifo_write_arbiter: RTL and testbench

//  Shares the single async-FIFO write port among NUM_REQ requesters in the write clock domain.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/fifo_write_arbiter_rr_pick.sv | 30 +++
 rtl/fifo_write_arbiter.sv | 111 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;

  assign dbl = {req, req};

  // Scan the doubled vector downwards so the lowest position in [ptr, ptr+N) wins last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i] && (i >= int'(ptr)) && (i < int'(ptr) + N)) begin
        any = 1'b1;
        idx = IW'(i % N);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ requesters.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int IW         = clog2_min1(NUM_REQ),
  localparam int BW         = clog2_min1(MAX_BURST + 1)
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy,
  output logic [31:0]                   beat_total
);

  arb_state_e    state, state_nxt;
  logic [IW-1:0] rr_ptr, rr_nxt, grant_nxt, owner_next, pick_idx;
  logic [BW-1:0] beat_cnt, cnt_nxt;
  logic          pick_any, own_valid, own_last, accept;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign owner_next = (grant_id == IW'(NUM_REQ-1)) ? '0 : grant_id + IW'(1);

  // Owner mux, FSM next state and handshake outputs; everything is forced quiet while in reset.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    grant_nxt = grant_id;
    cnt_nxt   = beat_cnt;
    own_valid = 1'b0;
    own_last  = 1'b0;
    wdata     = '0;
    req_ready = '0;
    accept    = 1'b0;
    busy      = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        wdata     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_idx;
          cnt_nxt   = '0;
          state_nxt = ARB_BURST;
        end
      end
      ARB_BURST: begin
        busy = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (grant_id == IW'(i)) & ~wfull;
        end
        accept = own_valid & ~wfull;
        if (accept) begin
          cnt_nxt = beat_cnt + BW'(1);
          if (own_last || (beat_cnt == BW'(MAX_BURST-1))) begin
            state_nxt = ARB_IDLE;
            rr_nxt    = owner_next;
          end
        end else if (!own_valid) begin
          state_nxt = ARB_IDLE;
          rr_nxt    = owner_next;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
    winc = accept & wrst;
    if (!wrst) begin
      req_ready = '0;
      busy      = 1'b0;
    end
  end

  // State, round-robin pointer, grant and beat counters, with synchronous active-low reset.
  always_ff @(posedge wclk) begin
    if (!wrst) begin
      state      <= ARB_IDLE;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      grant_id   <= '0;
      beat_total <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
      grant_id <= grant_nxt;
      if (winc) begin
        beat_total <= beat_total + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: reset, rotation, last, full stall, withdraw, mid-burst reset.
module tb_fifo_write_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic                          wclk = 1'b0;
  logic                          wrst = 1'b0;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wfull;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;
  logic [1:0]                    grant_id;
  logic                          busy;
  logic [31:0]                   beat_total;

  int checks   = 0;
  int failures = 0;

  fifo_write_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wfull      (wfull),
    .winc       (winc),
    .wdata      (wdata),
    .grant_id   (grant_id),
    .busy       (busy),
    .beat_total (beat_total)
  );

  // Free-running write clock, 10 time units per period.
  always #5 wclk = ~wclk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic [NUM_REQ-1:0] last,
                               input logic full);
    req_valid = valid;
    req_last  = last;
    wfull     = full;
  endtask

  // Owner g is mid-burst and a beat is being written this cycle.
  task automatic checkBeat(input string tag, input int g);
    checkOutput({tag, "_busy"},  32'(busy),      32'd1);
    checkOutput({tag, "_grant"}, 32'(grant_id),  32'(g));
    checkOutput({tag, "_winc"},  32'(winc),      32'd1);
    checkOutput({tag, "_wdata"}, 32'(wdata),     32'(8'hA0 + g));
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'(1 << g));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"},  32'(busy),      32'd0);
    checkOutput({tag, "_winc"},  32'(winc),      32'd0);
    checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_data[i*DATA_WIDTH +: DATA_WIDTH] = 8'(8'hA0 + i);
    end
    applyStimulus(4'b1111, 4'b0000, 1'b0);
    wrst = 1'b0;

    // T1: held in reset with every requester asking
    repeat (3) begin
      @(negedge wclk);
      checkIdle("t1_reset");
    end
    checkOutput("t1_total", beat_total, 32'd0);
    wrst = 1'b1;
    #1;
    checkIdle("t1_release");

    // T2: full rotation 0,1,2,3,0 with MAX_BURST beats each and a bubble after every grant
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < MAX_BURST; b++) begin
        @(negedge wclk);
        checkBeat("t2_beat", g % NUM_REQ);
      end
      @(negedge wclk);
      checkIdle("t2_bubble");
      if (g == 3) checkOutput("t2_total16", beat_total, 32'd16);
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // T3: requester 2 alone, last on its second beat
    @(negedge wclk);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    #1;
    checkIdle("t3_idle");
    @(negedge wclk);
    checkBeat("t3_beat1", 2);
    @(negedge wclk);
    applyStimulus(4'b0100, 4'b0100, 1'b0);
    #1;
    checkBeat("t3_beat2", 2);
    @(negedge wclk);
    applyStimulus(4'b1001, 4'b0000, 1'b0);
    #1;
    checkIdle("t3_done");
    checkOutput("t3_total", beat_total, 32'd22);

    // T5: search resumes at 3; owner 3 withdraws after one beat, then 0 wins after the bubble
    @(negedge wclk);
    checkBeat("t5_beat1", 3);
    @(negedge wclk);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    #1;
    checkOutput("t5_withdraw_winc", 32'(winc), 32'd0);
    checkOutput("t5_withdraw_busy", 32'(busy), 32'd1);
    @(negedge wclk);
    checkIdle("t5_release");
    @(negedge wclk);
    checkOutput("t5_regrant_busy", 32'(busy), 32'd1);
    checkOutput("t5_regrant_id", 32'(grant_id), 32'd0);
    applyStimulus(4'b0000, 4'b0000, 1'b0);

    // T4: requester 1 stalls on wfull for 5 clocks, then finishes a 4-beat burst
    @(negedge wclk);
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    #1;
    checkIdle("t4_idle");
    @(negedge wclk);
    checkBeat("t4_beat1", 1);
    @(negedge wclk);
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    #1;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge wclk);
      checkOutput("t4_stall_busy", 32'(busy), 32'd1);
      checkOutput("t4_stall_grant", 32'(grant_id), 32'd1);
      checkOutput("t4_stall_winc", 32'(winc), 32'd0);
      checkOutput("t4_stall_ready", 32'(req_ready), 32'd0);
    end
    @(negedge wclk);
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    #1;
    checkBeat("t4_beat2", 1);
    @(negedge wclk);
    checkBeat("t4_beat3", 1);
    @(negedge wclk);
    checkBeat("t4_beat4", 1);
    @(negedge wclk);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    #1;
    checkIdle("t4_done");
    checkOutput("t4_total", beat_total, 32'd27);

    // T6: reset asserted during beat 2 of requester 2; pointer must restart at 0
    @(negedge wclk);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    #1;
    checkIdle("t6_idle");
    @(negedge wclk);
    checkBeat("t6_beat1", 2);
    @(negedge wclk);
    checkBeat("t6_beat2", 2);
    wrst = 1'b0;
    #1;
    checkIdle("t6_in_reset");
    @(negedge wclk);
    applyStimulus(4'b0110, 4'b0000, 1'b0);
    wrst = 1'b1;
    #1;
    checkIdle("t6_after");
    checkOutput("t6_total", beat_total, 32'd0);
    @(negedge wclk);
    checkOutput("t6_regrant_busy", 32'(busy), 32'd1);
    checkOutput("t6_regrant_id", 32'(grant_id), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
